// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte buffer feeding uart_tx.
// The host pushes bytes with wr_en. The head byte is presented first-word-fall-through
// on tx_data/tx_valid and is popped when tx_valid && tx_ready.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_data, wr_en         host write port, one byte per cycle
//   flush                  synchronous clear of buffered contents
//   clr_overflow           clears the sticky overflow flag
//   full, almost_full      level == DEPTH, level >= AFULL_THRESH
//   empty, level           level == 0, current entry count (0..DEPTH)
//   overflow               sticky: a write was dropped while full
//   tx_data, tx_valid      head-of-queue byte and valid, to uart_tx
//   tx_ready               from uart_tx
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BITS-1:0]     wr_data,
    input  logic                     wr_en,
    input  logic                     flush,
    input  logic                     clr_overflow,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_BITS-1:0]     tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
    logic [LVL_W-1:0] level_n;
    logic             holdoff, holdoff_n;
    logic             overflow_n;

    logic wr_accept;
    logic pop;
    logic ovf_event;

    // Status flags decode from the registered level
    assign full        = (level == LVL_W'(DEPTH));
    assign empty       = (level == LVL_W'(0));
    assign almost_full = (level >= LVL_W'(AFULL_THRESH));

    // Holdoff masks tx_valid for one cycle after each pop, absorbing uart_tx's late tx_ready
    assign tx_valid = !empty && !holdoff;
    assign tx_data  = empty ? '0 : mem[rd_ptr];

    assign wr_accept = wr_en && !full && !flush;
    assign ovf_event = wr_en && full && !flush;
    assign pop       = tx_valid && tx_ready && !flush;

    // Next-state for pointers, level, holdoff and overflow
    always_comb begin
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        level_n    = level;
        holdoff_n  = 1'b0;
        overflow_n = overflow;

        // A new overflow event takes precedence over a clear in the same cycle
        if (clr_overflow) begin
            overflow_n = 1'b0;
        end
        if (ovf_event) begin
            overflow_n = 1'b1;
        end

        if (flush) begin
            wr_ptr_n  = '0;
            rd_ptr_n  = '0;
            level_n   = '0;
            holdoff_n = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_n = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            holdoff_n = pop;
            case ({wr_accept, pop})
                2'b10:   level_n = level + LVL_W'(1);
                2'b01:   level_n = level - LVL_W'(1);
                default: level_n = level;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            holdoff  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            level    <= level_n;
            holdoff  <= holdoff_n;
            overflow <= overflow_n;
        end
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule
